fir_stream_filter: RTL and testbench



---
 rtl/fir_stream_filter.sv | 125 ++++++++++++
 tb/tb_fir_stream_filter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_filter.sv
// Streaming pipelined FIR filter with a valid/ready interface and
// runtime-programmable coefficients.
//
// Stage 1 registers the TAPS products coef[i]*tap[i]. Stage 2 registers
// their full-precision sum.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  sample input handshake (in_ready is combinational)
//   in_data         input sample, DATA_W bits
//   out_valid/ready result output handshake
//   out_data        filtered result, OUT_W bits
//   coef_we/addr    coefficient write strobe and index
//   coef_wdata      coefficient value
//   flush           synchronous clear of the delay line and pipeline
module fir_stream_filter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic                     flush
);

  localparam int unsigned PW  = DATA_W + COEF_W;
  localparam int unsigned XW  = OUT_W - PW;
  localparam bit          SGN = (SIGNED != 0);

  logic [COEF_W-1:0] coef_q [TAPS];
  logic [DATA_W-1:0] dl_q   [TAPS-1];
  logic [DATA_W-1:0] tap_w  [TAPS];
  logic [PW-1:0]     prod_d [TAPS];
  logic [PW-1:0]     prod_q [TAPS];
  logic              s1_valid_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [OUT_W-1:0]  sum_d;
  logic              advance;
  logic              accept;
  logic              coef_hit;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = !rst && advance;
  assign accept    = in_valid && in_ready;
  assign coef_hit  = coef_we && (32'(coef_addr) < TAPS);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Per-tap product. Operands are extended to the product width so a single
  // same-width multiply is correct for both unsigned and two's complement.
  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    logic [PW-1:0] t_ext;
    logic [PW-1:0] c_ext;
    if (g == 0) begin : g_new
      assign tap_w[g] = in_data;
    end else begin : g_old
      assign tap_w[g] = dl_q[g-1];
    end
    assign t_ext     = {{COEF_W{SGN && tap_w[g][DATA_W-1]}}, tap_w[g]};
    assign c_ext     = {{DATA_W{SGN && coef_q[g][COEF_W-1]}}, coef_q[g]};
    assign prod_d[g] = t_ext * c_ext;
  end

  // Full-precision adder tree input: products extended to OUT_W.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_d = sum_d + {{XW{SGN && prod_q[i][PW-1]}}, prod_q[i]};
    end
  end

  // Pipeline, delay line and coefficient storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= COEF_W'(i + 1);
        prod_q[i] <= '0;
      end
      for (int i = 0; i < TAPS - 1; i++) begin
        dl_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (coef_hit) begin
        coef_q[coef_addr] <= coef_wdata;
      end
      if (flush) begin
        // Coefficients survive a flush; any same-cycle sample is dropped.
        for (int i = 0; i < TAPS - 1; i++) begin
          dl_q[i] <= '0;
        end
        s1_valid_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else if (advance) begin
        out_valid_q <= s1_valid_q;
        out_data_q  <= sum_d;
        s1_valid_q  <= accept;
        if (accept) begin
          dl_q[0] <= in_data;
          for (int i = 1; i < TAPS - 1; i++) begin
            dl_q[i] <= dl_q[i-1];
          end
          for (int i = 0; i < TAPS; i++) begin
            prod_q[i] <= prod_d[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_filter.sv
module tb_fir_stream_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Unsigned instance
  logic        rst, in_valid, in_ready, out_valid, out_ready, coef_we, flush;
  logic [7:0]  in_data, coef_wdata;
  logic [1:0]  coef_addr;
  logic [17:0] out_data;

  // Signed instance
  logic        s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_coef_we, s_flush;
  logic [7:0]  s_in_data, s_coef_wdata;
  logic [1:0]  s_coef_addr;
  logic [17:0] s_out_data;

  fir_stream_filter #(.DATA_W(8), .TAPS(4), .COEF_W(8), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .flush(flush)
  );

  fir_stream_filter #(.DATA_W(8), .TAPS(4), .COEF_W(8), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .coef_we(s_coef_we), .coef_addr(s_coef_addr), .coef_wdata(s_coef_wdata), .flush(s_flush)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        fl;
    logic        we;
    logic [1:0]  a;
    logic [7:0]  wd;
    logic        eov;
    logic [17:0] eod;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic fl, input logic we, input logic [1:0] a,
                              input logic [7:0] wd, input logic eov, input logic [17:0] eod);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.fl = fl; x.we = we;
    x.a = a; x.wd = wd; x.eov = eov; x.eod = eod;
    return x;
  endfunction

  function automatic vec_t vr();
    return mk(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 18'd0);
  endfunction

  function automatic vec_t vs(input logic v, input logic [7:0] d, input logic eov, input logic [17:0] eod);
    return mk(1'b0, v, d, 1'b0, 1'b0, 2'd0, 8'd0, eov, eod);
  endfunction

  // Signed-instance single cycle: drive, then check outputs before the edge.
  task automatic s_step(input string nm, input logic r, input logic v, input logic [7:0] d,
                        input logic we, input logic [1:0] a, input logic [7:0] wd,
                        input logic eov, input logic [17:0] eod);
    @(negedge clk);
    s_rst = r; s_in_valid = v; s_in_data = d;
    s_coef_we = we; s_coef_addr = a; s_coef_wdata = wd;
    #1;
    cmp({nm, " out_valid"}, 32'(s_out_valid), 32'(eov));
    if (eov || r) cmp({nm, " out_data"}, 32'(s_out_data), 32'(eod));
    if (r) cmp({nm, " in_ready"}, 32'(s_in_ready), 32'd0);
  endtask

  // Backpressure scoreboard state
  logic [17:0] bp_exp [8];
  logic [17:0] bp_res [$];
  int          bp_idx, bp_got, bp_cyc;
  logic        bp_prev_stall;
  logic [17:0] bp_prev_od;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; flush = 1'b0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    s_coef_we = 1'b0; s_coef_addr = '0; s_coef_wdata = '0; s_flush = 1'b0;

    // Impulse 1,0,0,0,0 -> 1,2,3,4,0
    tv.push_back(vr());
    tv.push_back(vs(1, 8'd1, 0, 18'd0));
    tv.push_back(vs(1, 8'd0, 0, 18'd0));
    tv.push_back(vs(1, 8'd0, 1, 18'd1));
    tv.push_back(vs(1, 8'd0, 1, 18'd2));
    tv.push_back(vs(1, 8'd0, 1, 18'd3));
    tv.push_back(vs(0, 8'd0, 1, 18'd4));
    tv.push_back(vs(0, 8'd0, 1, 18'd0));
    tv.push_back(vs(0, 8'd0, 0, 18'd0));
    // Full-scale step 255 x5 -> 255,765,1530,2550,2550
    tv.push_back(vr());
    for (int i = 0; i < 2; i++) tv.push_back(vs(1, 8'd255, 0, 18'd0));
    tv.push_back(vs(1, 8'd255, 1, 18'd255));
    tv.push_back(vs(1, 8'd255, 1, 18'd765));
    tv.push_back(vs(1, 8'd255, 1, 18'd1530));
    tv.push_back(vs(0, 8'd0, 1, 18'd2550));
    tv.push_back(vs(0, 8'd0, 1, 18'd2550));
    tv.push_back(vs(0, 8'd0, 0, 18'd0));
    // coef[0]=10 written alongside sample 1, then sample 2 -> 1, 22
    tv.push_back(vr());
    tv.push_back(mk(0, 1, 8'd1, 0, 1, 2'd0, 8'd10, 0, 18'd0));
    tv.push_back(vs(1, 8'd2, 0, 18'd0));
    tv.push_back(vs(0, 8'd0, 1, 18'd1));
    tv.push_back(vs(0, 8'd0, 1, 18'd22));
    tv.push_back(vs(0, 8'd0, 0, 18'd0));
    // Flush after three 5s drops the same-cycle 9; then 7 alone -> 7
    tv.push_back(vr());
    tv.push_back(vs(1, 8'd5, 0, 18'd0));
    tv.push_back(vs(1, 8'd5, 0, 18'd0));
    tv.push_back(vs(1, 8'd5, 1, 18'd5));
    tv.push_back(mk(0, 1, 8'd9, 1, 0, 2'd0, 8'd0, 1, 18'd15));
    tv.push_back(vs(1, 8'd7, 0, 18'd0));
    tv.push_back(vs(0, 8'd0, 0, 18'd0));
    tv.push_back(vs(0, 8'd0, 1, 18'd7));
    tv.push_back(vs(0, 8'd0, 0, 18'd0));
    tv.push_back(vr());

    repeat (2) @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst; in_valid = tv[i].v; in_data = tv[i].d; out_ready = 1'b1;
      flush = tv[i].fl; coef_we = tv[i].we; coef_addr = tv[i].a; coef_wdata = tv[i].wd;
      #1;
      cmp($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(!tv[i].rst));
      cmp($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tv[i].eov));
      if (tv[i].eov || tv[i].rst)
        cmp($sformatf("row%0d out_data", i), 32'(out_data), 32'(tv[i].eod));
    end

    // Backpressure: samples 1..8, out_ready pattern 1,0,0 repeating
    bp_exp = '{18'd1, 18'd4, 18'd10, 18'd20, 18'd30, 18'd40, 18'd50, 18'd60};
    bp_idx = 0; bp_got = 0; bp_cyc = 0; bp_prev_stall = 1'b0; bp_prev_od = '0;
    while (bp_got < 8 && bp_cyc < 200) begin
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; coef_we = 1'b0;
      out_ready = (bp_cyc % 3 == 0);
      in_valid  = (bp_idx < 8);
      in_data   = 8'(bp_idx + 1);
      #1;
      if (bp_prev_stall) begin
        cmp($sformatf("bp%0d hold valid", bp_cyc), 32'(out_valid), 32'd1);
        cmp($sformatf("bp%0d hold data", bp_cyc), 32'(out_data), 32'(bp_prev_od));
      end
      if (out_valid && !out_ready)
        cmp($sformatf("bp%0d stall in_ready", bp_cyc), 32'(in_ready), 32'd0);
      if (!out_valid || out_ready)
        cmp($sformatf("bp%0d free in_ready", bp_cyc), 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        bp_res.push_back(out_data);
        bp_got++;
      end
      if (in_valid && in_ready) bp_idx++;
      bp_prev_stall = out_valid && !out_ready;
      bp_prev_od    = out_data;
      bp_cyc++;
    end
    cmp("bp result count", 32'(bp_got), 32'd8);
    for (int k = 0; k < 8; k++)
      cmp($sformatf("bp result%0d", k),
          (k < bp_res.size()) ? 32'(bp_res[k]) : 32'hffff_ffff, 32'(bp_exp[k]));

    // Signed instance: coefs all 1, -128 x4 -> -512; reset mid-stream
    @(negedge clk);
    s_rst = 1'b0;
    for (int k = 0; k < 4; k++)
      s_step($sformatf("s_wr%0d", k), 0, 0, 8'd0, 1, 2'(k), 8'd1, 0, 18'd0);
    s_step("s_a0", 0, 1, 8'h80, 0, 2'd0, 8'd0, 0, 18'd0);
    s_step("s_a1", 0, 1, 8'h80, 0, 2'd0, 8'd0, 0, 18'd0);
    s_step("s_a2", 0, 1, 8'h80, 0, 2'd0, 8'd0, 1, 18'(-128));
    s_step("s_a3", 0, 1, 8'h80, 0, 2'd0, 8'd0, 1, 18'(-256));
    s_step("s_a4", 0, 1, 8'd0,  0, 2'd0, 8'd0, 1, 18'(-384));
    s_step("s_a5", 0, 1, 8'd0,  0, 2'd0, 8'd0, 1, 18'(-512));
    s_step("s_rst", 1, 1, 8'd0, 0, 2'd0, 8'd0, 0, 18'd0);
    s_step("s_i0", 0, 1, 8'd1, 0, 2'd0, 8'd0, 0, 18'd0);
    s_step("s_i1", 0, 1, 8'd0, 0, 2'd0, 8'd0, 0, 18'd0);
    s_step("s_i2", 0, 1, 8'd0, 0, 2'd0, 8'd0, 1, 18'd1);
    s_step("s_i3", 0, 1, 8'd0, 0, 2'd0, 8'd0, 1, 18'd2);
    s_step("s_i4", 0, 0, 8'd0, 0, 2'd0, 8'd0, 1, 18'd3);
    s_step("s_i5", 0, 0, 8'd0, 0, 2'd0, 8'd0, 1, 18'd4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
